// File: rtl/neuron_mac.sv
// neuron_mac: accumulates N_INPUTS signed x*w products plus a bias in Q3.4,
// then scales and saturates the sum to an 8-bit pre-activation value.
// out_start pulses one cycle after out_result settles, so an edge-triggered
// activation stage always samples a stable operand.
module neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int FRAC     = 4,
  parameter int ACC_W    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bias,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x,
  input  logic [7:0] w,
  output logic [7:0] out_result,
  output logic       saturated,
  output logic       out_start
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-128);

  typedef enum logic [1:0] {
    ST_ACC,
    ST_SAT,
    ST_START
  } state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [15:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  scaled;
  logic                     accept;
  logic                     last_beat;

  // NOTE: in_ready is decoded from the state register alone, never from
  // in_valid, so there is no combinational path through the handshake and
  // it reads 1 while reset holds the state at ST_ACC.
  assign in_ready  = (state == ST_ACC);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == LAST_CNT);

  // Full-precision product, then sign extension into the accumulator width.
  assign prod     = $signed(x) * $signed(w);
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  assign bias_ext = {{(ACC_W-8){bias[7]}}, bias} <<< FRAC;

  // Drop the fraction; arithmetic shift rounds toward minus infinity.
  assign scaled = acc >>> FRAC;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register in a clocked block uses non-blocking assignment so
    // all flops update together from the pre-edge values.
    if (!rst_n) state <= ST_ACC;
    else        state <= state_next;
  end

  // Next-state decode: ACC until the last beat, one SAT cycle, then START
  // holds for two cycles so out_start rises a full cycle after out_result.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_ACC:   if (accept && last_beat) state_next = ST_SAT;
      ST_SAT:   state_next = ST_START;
      ST_START: if (out_start) state_next = ST_ACC;
      default:  state_next = ST_ACC;
    endcase
  end

  // Beat counter and accumulator; bias is folded in on beat 0 only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      cnt <= last_beat ? '0 : cnt + 1'b1;
      if (cnt == '0) acc <= prod_ext + bias_ext;
      else           acc <= acc + prod_ext;
    end
  end

  // Saturating output register; holds its value until the next SAT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      saturated  <= 1'b0;
    end else if (state == ST_SAT) begin
      if (scaled > SAT_MAX) begin
        out_result <= 8'h7f;
        saturated  <= 1'b1;
      end else if (scaled < SAT_MIN) begin
        out_result <= 8'h80;
        saturated  <= 1'b1;
      end else begin
        out_result <= scaled[7:0];
        saturated  <= 1'b0;
      end
    end
  end

  // Start pulse: set on the first START cycle, cleared on the way back to ACC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 out_start <= 1'b0;
    else if (state == ST_START) out_start <= !out_start;
    else                        out_start <= 1'b0;
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: a transaction-level reference model predicts the
// outputs every cycle; directed evaluations pin the model with literal values
// and randomized gapped traffic exercises the handshake.
module tb_neuron_mac;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] bias = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x = '0;
  logic [7:0] w = '0;
  logic [7:0] out_result;
  logic       saturated;
  logic       out_start;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  neuron_mac #(.N_INPUTS(N), .FRAC(4), .ACC_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .bias(bias), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .w(w), .out_result(out_result),
    .saturated(saturated), .out_start(out_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // ---------------- reference model ----------------
  // Beats are summed with plain integer arithmetic; after the last beat the
  // block is busy for three cycles: result visible after one, start pulse
  // during the third.
  int   m_busy = 0;
  int   m_cnt = 0;
  int   m_sum = 0;
  int   m_pend_res = 0;
  bit   m_pend_sat = 0;
  int   m_res = 0;
  bit   m_sat = 0;
  bit   m_start = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_cnt = 0; m_sum = 0;
      m_res = 0; m_sat = 0; m_start = 0;
    end else if (m_busy == 0) begin
      if (in_valid) begin
        if (m_cnt == 0) m_sum = int'($signed(bias)) * 16;
        m_sum += int'($signed(x)) * int'($signed(w));
        m_cnt++;
        if (m_cnt == N) begin
          int s;
          s = m_sum >>> 4;
          if (s > 127)       begin m_pend_res = 127;  m_pend_sat = 1; end
          else if (s < -128) begin m_pend_res = -128; m_pend_sat = 1; end
          else               begin m_pend_res = s;    m_pend_sat = 0; end
          m_cnt  = 0;
          m_busy = 3;
        end
      end
    end else begin
      if (m_busy == 3) begin m_res = m_pend_res & 8'hff; m_sat = m_pend_sat; end
      if (m_busy == 2) m_start = 1;
      if (m_busy == 1) m_start = 0;
      m_busy--;
    end
  end

  // Per-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", int'(in_ready), int'(m_busy == 0));
      check("out_start", int'(out_start), int'(m_start));
      check("out_result", int'(out_result), m_res);
      check("saturated", int'(saturated), int'(m_sat));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_beat(input logic [7:0] b, input logic [7:0] xv, input logic [7:0] wv);
    int guard = 0;
    @(negedge clk);
    bias = b; x = xv; w = wv; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      vectors++; miscompares++;
      $display("FAIL beat_timeout at %0t: in_ready stayed 0", $time);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Waits (in_valid still high) for the start pulse, then drops in_valid
  // before the block returns to ACC and checks the literal expectation.
  task automatic wait_start(input string name, input int lit_res, input int lit_sat);
    int guard = 0;
    @(negedge clk);
    while (!out_start && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 10) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout at %0t: out_start never rose", name, $time);
    end
    check({name, "_result"}, int'(out_result), lit_res);
    check({name, "_sat"}, int'(saturated), lit_sat);
    check({name, "_model"}, m_res, lit_res);
  endtask

  task automatic eval4(input logic [7:0] b, input logic [7:0] xv, input logic [7:0] wv);
    for (int i = 0; i < N; i++) send_beat(b, xv, wv);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check("rst_ready", int'(in_ready), 1);
    check("rst_result", int'(out_result), 0);
    check("rst_start", int'(out_start), 0);
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    #1 rst_n = 1'b1;

    // Basic sum: 4 x (1.0*1.0) = 4.0 -> 0x40
    eval4(8'd0, 8'd16, 8'd16);
    wait_start("basic", 8'h40, 0);
    // Positive saturation
    eval4(8'd0, 8'd127, 8'd127);
    wait_start("pos_sat", 8'h7f, 1);
    // Negative saturation
    eval4(8'd0, 8'h80, 8'd127);
    wait_start("neg_sat", 8'h80, 1);
    // Floor shift: -1/256 rounds to -1/16
    send_beat(8'd0, 8'hff, 8'd1);
    for (int i = 1; i < N; i++) send_beat(8'd0, 8'd0, 8'd0);
    wait_start("floor", 8'hff, 0);
    // Bias path
    eval4(8'd8, 8'd0, 8'd0);
    wait_start("bias_pos", 8'h08, 0);
    eval4(8'hf8, 8'd0, 8'd0);
    wait_start("bias_neg", 8'hf8, 0);
    // Bias changed after beat 0 must not matter
    send_beat(8'd8, 8'd0, 8'd0);
    for (int i = 1; i < N; i++) send_beat(8'hfb, 8'd0, 8'd0);
    wait_start("bias_hold", 8'h08, 0);

    // Mid-evaluation async reset
    send_beat(8'd5, 8'd100, 8'd100);
    send_beat(8'd5, 8'd100, 8'd100);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("midrst_ready", int'(in_ready), 1);
    check("midrst_result", int'(out_result), 0);
    check("midrst_start", int'(out_start), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    eval4(8'd0, 8'd16, 8'd16);
    wait_start("post_rst", 8'h40, 0);

    // Async reset while out_start is high
    eval4(8'd0, 8'd32, 8'd16);
    wait_start("pre_rst2", 8'h80 >> 0 == 8'h80 ? 8'h7f : 0, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_kills_start", int'(out_start), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Randomized evaluations: random gaps, in_valid held through SAT/START
    for (int e = 0; e < 40; e++) begin
      logic [7:0] b;
      b = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send_beat((i == 0) ? b : 8'($urandom), 8'($urandom), 8'($urandom));
      end
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
